// File: rtl/synapse_pkg.sv
// Shared types and defaults for the synapse memory loader.
// The FSM state encoding and parameter defaults live here.
package synapse_pkg;

  localparam int SYN_DATA_WIDTH  = 8;
  localparam int SYN_ADDR_WIDTH  = 14;
  localparam int SYN_DEPTH       = 10000;
  localparam int SYN_CKSUM_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_t;

endpackage

// File: rtl/synapse_ld_cksum.sv
// Running modulo-2^16 sum of sign-extended weights for one load.
// Only built when SYN_LOADER_CHECKSUM_EN is defined.
module synapse_ld_cksum
  import synapse_pkg::*;
#(
  parameter int DATA_WIDTH = SYN_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       add,
  input  logic [DATA_WIDTH-1:0]      din,
  output logic [SYN_CKSUM_WIDTH-1:0] sum
);

  logic signed [DATA_WIDTH-1:0] sdin;

  assign sdin = din;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (add) begin
      sum <= sum + SYN_CKSUM_WIDTH'(sdin);
    end
  end

endmodule

// File: rtl/synapse_mem_loader.sv
// Streams weights into the synapse memory write port.
// Optional o_checksum output under SYN_LOADER_CHECKSUM_EN.
module synapse_mem_loader
  import synapse_pkg::*;
#(
  parameter int DATA_WIDTH = SYN_DATA_WIDTH,
  parameter int ADDR_WIDTH = SYN_ADDR_WIDTH,
  parameter int DEPTH      = SYN_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_count,
  input  logic                  i_abort,
  input  logic                  i_wr_valid,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ready,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_din,
  output logic                  o_busy,
  output logic                  o_done,
`ifdef SYN_LOADER_CHECKSUM_EN
  output logic [SYN_CKSUM_WIDTH-1:0] o_checksum,
`endif
  output logic                  o_err
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int EW = ADDR_WIDTH + 2;
  localparam logic [EW-1:0] DEPTH_W = EW'(DEPTH);

  ld_state_t             state_q;
  ld_state_t             state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0]         rem_q;
  logic [EW-1:0]         end_addr;
  logic                  start_acc;
  logic                  start_bad;
  logic                  beat;
  logic                  last_beat;

  assign end_addr = {2'b00, i_base_addr} + {1'b0, i_count};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    start_acc  = 1'b0;
    start_bad  = 1'b0;
    beat       = 1'b0;
    last_beat  = 1'b0;
    o_wr_ready = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        start_acc = i_start & ~rst;
        if (start_acc) begin
          if (i_count == '0) begin
            state_d = ST_DONE;
          end else if (end_addr > DEPTH_W) begin
            start_bad = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        o_busy     = 1'b1;
        o_wr_ready = ~i_abort & ~rst;
        beat       = i_wr_valid & o_wr_ready;
        last_beat  = beat & (rem_q == CW'(1));
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (last_beat) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        o_busy  = 1'b1;
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Address stops on the final beat so it never walks past DEPTH-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      rem_q      <= '0;
      o_mem_we   <= 1'b0;
      o_mem_addr <= '0;
      o_mem_din  <= '0;
      o_err      <= 1'b0;
    end else begin
      o_mem_we <= beat;
      if (start_bad) begin
        o_err <= 1'b1;
      end else if (start_acc) begin
        o_err <= 1'b0;
      end
      if (start_acc) begin
        addr_q <= i_base_addr;
        rem_q  <= i_count;
      end else if (beat) begin
        o_mem_addr <= addr_q;
        o_mem_din  <= i_wr_data;
        rem_q      <= rem_q - CW'(1);
        if (!last_beat) begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
        end
      end
    end
  end

`ifdef SYN_LOADER_CHECKSUM_EN
  synapse_ld_cksum #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cksum (
    .clk(clk),
    .rst(rst),
    .clr(start_acc),
    .add(beat),
    .din(i_wr_data),
    .sum(o_checksum)
  );
`endif

endmodule
